regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Sequential reader that walks a contiguous range of the RISC-V register file through one combinational read port and streams each register value out over a valid/ready interface. It sits between the core's register file and the Zynq PS-side debug/telemetry path. It lets the processing system capture an architectural register snapshot without tapping the 32 flat debug buses. While busy, it asserts a freeze request so the core can stall writeback and keep the snapshot consistent.

## Interface
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; takes effect in any non-IDLE state.
- rd_addr  out  5  register file read address; equals the internal index register.
- rd_data  in  32  register file read data, combinational from rd_addr.
- m_valid  out  1  stream word valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  32  stream word.
- m_index  out  5  register index of the current word.
- m_last  out  1  marks the final word of the dump.
- m_csum  out  1  marks the checksum word; constant 0 without REGDUMP_CHECKSUM_EN.
- busy  out  1  high in every state except IDLE.
- freeze  out  1  equals busy; requests the core to hold register writes.
- done  out  1  one-cycle pulse on dump completion; no pulse on abort.

## Operation
- States: IDLE, LOAD, SEND, CSUM (only with the macro), DONE.
- IDLE, start=1:
  - idx<=FIRST_REG, acc<=0.
  - Go to LOAD.
- LOAD:
  - m_data<=rd_data, m_index<=idx, m_valid<=1.
  - m_last<=(idx==LAST_REG) when the checksum macro is off; m_last<=0 when it is on.
  - Go to SEND.
- SEND:
  - Hold m_data, m_index and m_last stable while m_valid=1 and m_ready=0.
  - On handshake (m_valid&m_ready): m_valid<=0 and acc<=acc^m_data.
  - After the handshake, if idx!=LAST_REG: idx<=idx+1 and go to LOAD.
  - After the handshake, if idx==LAST_REG: go to CSUM (macro on) or DONE (macro off).
- CSUM:
  - Entry cycle loads m_data<=acc, m_csum<=1, m_last<=1, m_index<=LAST_REG, m_valid<=1.
  - Hold all fields until handshake, then clear m_valid, m_csum and m_last and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Index arithmetic: idx is 5-bit and never wraps, because it stops at LAST_REG. Word count = LAST_REG-FIRST_REG+1 (+1 with checksum).
- acc is a 32-bit XOR accumulator with no carries.
- start while busy is ignored; it is not queued.
- abort:
  - Next state is IDLE; m_valid, m_last and m_csum clear.
  - No done pulse is produced.
  - abort has priority over a simultaneous handshake; that word counts as not transferred.
- start and abort asserted together in IDLE: abort has no effect, so start wins.
- Reset mid-dump: immediate return to IDLE with all reset values.
- Reset values: state IDLE, idx=0 (so rd_addr=0), m_valid=0, m_data=0, m_index=0, m_last=0, m_csum=0, busy=0, freeze=0, done=0, acc=0.

## Timing
- start sampled at edge N:
  - busy and freeze are high after edge N.
  - rd_addr=FIRST_REG during cycle N..N+1.
  - First m_valid is high after edge N+1.
- Each word costs 2 cycles minimum (LOAD + SEND), so peak throughput is 1 word per 2 cycles.
- After any handshake, m_valid is low for exactly one cycle before the next word.
- rd_data must settle within one cycle of rd_addr changing; the read port is combinational.
- done rises on the edge after the final handshake (DONE state), busy falls one edge later.
- Full default dump with m_ready tied high: 64 cycles from start edge to done (66 with checksum).
- m_valid never drops without a handshake, except on abort or rst.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - CSUM state and the 32-bit accumulator exist.
  - An extra trailing word carries the XOR of all dumped words, with m_csum=1 and m_last=1.
- REGDUMP_CHECKSUM_EN undefined:
  - No accumulator and no CSUM state.
  - m_last is on the LAST_REG word and m_csum is tied 0.

## Test plan
- Default params, register file at power-up contents (x0=0, x1..x31=1), m_ready=1, start pulse -> 32 words; index 0 data 0x00000000, indices 1..31 data 0x00000001; m_last only on index 31; done pulse at cycle 64; busy low after.
- Same with REGDUMP_CHECKSUM_EN -> 33rd word data 0x00000001 (XOR of 31 ones), m_csum=1, m_last=1, m_index=31; the index 31 data word has m_last=0.
- FIRST_REG=5, LAST_REG=5, x5=0xDEADBEEF, m_ready held low 10 cycles then high -> single word 0xDEADBEEF held stable all 10 cycles; m_last=1; done one cycle after handshake.
- Random m_ready backpressure, registers preloaded with x[i]=i*0x01010101 -> every word matches its index; no word is dropped or duplicated; m_valid never drops before handshake.
- abort asserted during SEND of index 10 with m_ready=1 in the same cycle -> IDLE next edge, m_valid=0, no done pulse; a new start restarts from FIRST_REG.
- rst asserted mid-dump (index 17, asynchronously between edges) -> all outputs return immediately to reset values (rd_addr=0, busy=0); start during the dump is ignored, not queued.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks register indices FIRST_REG..LAST_REG through one combinational
// register-file read port and streams each value over a valid/ready port.
// While a dump is in flight, busy/freeze ask the core to hold writeback so
// the snapshot stays consistent.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   defined   -> a trailing checksum word (XOR of all dumped words) is sent
//                with m_csum=1 and m_last=1
//   undefined -> no accumulator, no CSUM state, m_last on the LAST_REG word,
//                m_csum tied low
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [4:0]  m_index,
    output logic        m_last,
    output logic        m_csum,
    output logic        busy,
    output logic        freeze,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd4
    } state_t;
`endif

    state_t      state_r;
    state_t      next_state_s;
    logic [4:0]  idx_r;
    logic        m_valid_r;
    logic [31:0] m_data_r;
    logic [4:0]  m_index_r;
    logic        m_last_r;
    logic        handshake_s;
    logic        at_last_s;

`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] acc_r;
    logic        m_csum_r;

    // XOR folding has no carries, so the checksum is order independent.
    function automatic logic [31:0] csum_fold(input logic [31:0] acc, input logic [31:0] word);
        csum_fold = acc ^ word;
    endfunction
`endif

    assign handshake_s = m_valid_r & m_ready;
    assign at_last_s   = (idx_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort wins over everything except in IDLE, where only start counts.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (handshake_s) begin
                    if (at_last_s) begin
`ifdef REGDUMP_CHECKSUM_EN
                        next_state_s = ST_CSUM;
`else
                        next_state_s = ST_DONE;
`endif
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else begin
                    next_state_s = ST_SEND;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (handshake_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Index register and output word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r     <= 5'd0;
            m_valid_r <= 1'b0;
            m_data_r  <= 32'd0;
            m_index_r <= 5'd0;
            m_last_r  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            m_csum_r  <= 1'b0;
`endif
        end else if (abort && (state_r != ST_IDLE)) begin
            // A word on the bus during abort is treated as not transferred.
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            m_csum_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_r <= FIRST_IDX;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_LOAD: begin
                    m_data_r  <= rd_data;
                    m_index_r <= idx_r;
                    m_valid_r <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    m_last_r  <= 1'b0;
`else
                    m_last_r  <= at_last_s;
`endif
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        m_valid_r <= 1'b0;
                        if (!at_last_s) begin
                            idx_r <= idx_r + 5'd1;
                        end else begin
                            idx_r <= idx_r;
                        end
                    end else begin
                        m_valid_r <= m_valid_r;
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (!m_valid_r) begin
                        m_data_r  <= acc_r;
                        m_index_r <= LAST_IDX;
                        m_last_r  <= 1'b1;
                        m_csum_r  <= 1'b1;
                        m_valid_r <= 1'b1;
                    end else if (handshake_s) begin
                        m_valid_r <= 1'b0;
                        m_last_r  <= 1'b0;
                        m_csum_r  <= 1'b0;
                    end else begin
                        m_valid_r <= m_valid_r;
                    end
                end
`endif
                ST_DONE: begin
                    m_valid_r <= 1'b0;
                end
                default: begin
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    m_csum_r  <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Checksum accumulator: cleared on start, folds in each accepted data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            acc_r <= 32'd0;
        end else if ((state_r == ST_SEND) && handshake_s && !abort) begin
            acc_r <= csum_fold(acc_r, m_data_r);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign m_csum = m_csum_r;
`else
    assign m_csum = 1'b0;
`endif

    assign rd_addr = idx_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_index = m_index_r;
    assign m_last  = m_last_r;
    assign busy    = (state_r != ST_IDLE);
    assign freeze  = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed testbench for regfile_dump_reader. Instance A uses the default
// range 0..31; instance B dumps a single register (5..5).
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_ON   = 1'b1;
    localparam int NWORDS    = 33;
    localparam int DONE_CYC  = 66;
`else
    localparam bit CSUM_ON   = 1'b0;
    localparam int NWORDS    = 32;
    localparam int DONE_CYC  = 64;
`endif

    logic clk;
    logic rst;

    logic        start_a, abort_a, ready_a;
    logic [4:0]  rd_addr_a, m_index_a;
    logic [31:0] rd_data_a, m_data_a;
    logic        m_valid_a, m_last_a, m_csum_a, busy_a, freeze_a, done_a;
    logic [31:0] regs_a [32];

    logic        start_b, abort_b, ready_b;
    logic [4:0]  rd_addr_b, m_index_b;
    logic [31:0] rd_data_b, m_data_b;
    logic        m_valid_b, m_last_b, m_csum_b, busy_b, freeze_b, done_b;
    logic [31:0] regs_b [32];

    int n_checks = 0;
    int n_errors = 0;

    assign rd_data_a = regs_a[rd_addr_a];
    assign rd_data_b = regs_b[rd_addr_b];

    regfile_dump_reader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .m_valid(m_valid_a), .m_ready(ready_a), .m_data(m_data_a),
        .m_index(m_index_a), .m_last(m_last_a), .m_csum(m_csum_a),
        .busy(busy_a), .freeze(freeze_a), .done(done_a)
    );

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .m_valid(m_valid_b), .m_ready(ready_b), .m_data(m_data_b),
        .m_index(m_index_b), .m_last(m_last_b), .m_csum(m_csum_b),
        .busy(busy_b), .freeze(freeze_b), .done(done_b)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full dump on instance A; optional backpressure pattern; start is
    // pulsed mid-dump and must not queue a second dump.
    task automatic dump_a(input bit bp, input int exp_done);
        int          nw;
        logic [31:0] x;
        bit          fin;
        bit          prev_pend;
        logic [31:0] prev_data;
        nw = 0; x = 32'd0; fin = 1'b0; prev_pend = 1'b0; prev_data = 32'd0;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("start_busy", busy_a, 32'd1);
        check_eq("start_freeze", freeze_a, 32'd1);
        check_eq("start_rdaddr", rd_addr_a, 32'd0);
        for (int k = 1; k <= 400 && !fin; k++) begin
            @(negedge clk);
            start_a = (k == 20);
            if (prev_pend) begin
                check_eq("valid_hold", m_valid_a, 32'd1);
                check_eq("data_hold", m_data_a, prev_data);
            end
            ready_a   = bp ? (((k * 5) % 7) < 3) : 1'b1;
            prev_pend = m_valid_a && !ready_a;
            prev_data = m_data_a;
            if (m_valid_a && ready_a) begin
                if (nw < 32) begin
                    check_eq("word_data", m_data_a, regs_a[nw]);
                    check_eq("word_index", m_index_a, 32'(nw));
                    check_eq("word_last", m_last_a, 32'(!CSUM_ON && (nw == 31)));
                    check_eq("word_csum", m_csum_a, 32'd0);
                    x = x ^ regs_a[nw];
                end else begin
                    check_eq("csum_data", m_data_a, x);
                    check_eq("csum_index", m_index_a, 32'd31);
                    check_eq("csum_last", m_last_a, 32'd1);
                    check_eq("csum_flag", m_csum_a, 32'd1);
                end
                nw++;
            end
            if (done_a) begin
                fin = 1'b1;
                check_eq("word_count", 32'(nw), 32'(NWORDS));
                if (exp_done > 0) check_eq("done_cycle", 32'(k), 32'(exp_done));
            end
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        if (!fin) check_eq("done_seen", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("end_busy", busy_a, 32'd0);
        check_eq("end_done", done_a, 32'd0);
        @(negedge clk);
        check_eq("no_queue_busy", busy_a, 32'd0);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs_a[i] = (i == 0) ? 32'd0 : 32'd1;
            regs_b[i] = 32'd0;
        end
        regs_b[5] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values.
        check_eq("rst_valid", m_valid_a, 32'd0);
        check_eq("rst_data", m_data_a, 32'd0);
        check_eq("rst_index", m_index_a, 32'd0);
        check_eq("rst_last", m_last_a, 32'd0);
        check_eq("rst_csum", m_csum_a, 32'd0);
        check_eq("rst_busy", busy_a, 32'd0);
        check_eq("rst_freeze", freeze_a, 32'd0);
        check_eq("rst_done", done_a, 32'd0);
        check_eq("rst_rdaddr", rd_addr_a, 32'd0);

        // Power-up register contents, no backpressure.
        dump_a(1'b0, DONE_CYC);

        // Single-register dump with 10 cycles of backpressure.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("b_busy", busy_b, 32'd1);
        check_eq("b_rdaddr", rd_addr_b, 32'd5);
        @(negedge clk);
        check_eq("b_index", m_index_b, 32'd5);
        check_eq("b_last", m_last_b, 32'(!CSUM_ON));
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("b_hold_valid", m_valid_b, 32'd1);
            check_eq("b_hold_data", m_data_b, 32'hDEADBEEF);
        end
        ready_b = 1'b1;
        @(negedge clk);
        check_eq("b_after_valid", m_valid_b, 32'd0);
`ifdef REGDUMP_CHECKSUM_EN
        check_eq("b_csum_wait_done", done_b, 32'd0);
        @(negedge clk);
        check_eq("b_csum_valid", m_valid_b, 32'd1);
        check_eq("b_csum_data", m_data_b, 32'hDEADBEEF);
        check_eq("b_csum_flag", m_csum_b, 32'd1);
        check_eq("b_csum_last", m_last_b, 32'd1);
        @(negedge clk);
`endif
        check_eq("b_done", done_b, 32'd1);
        @(negedge clk);
        check_eq("b_done_pulse", done_b, 32'd0);
        check_eq("b_idle", busy_b, 32'd0);
        ready_b = 1'b0;

        // Patterned registers with backpressure.
        for (int i = 0; i < 32; i++) regs_a[i] = i * 32'h01010101;
        dump_a(1'b1, 0);

        // Abort during SEND of index 10 with a simultaneous handshake.
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_valid_a && (m_index_a == 5'd10)) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check_eq("abort_reach", 32'd0, 32'd1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_eq("abort_valid", m_valid_a, 32'd0);
        check_eq("abort_busy", busy_a, 32'd0);
        check_eq("abort_done", done_a, 32'd0);
        @(negedge clk);
        check_eq("abort_no_done", done_a, 32'd0);
        dump_a(1'b0, DONE_CYC);

        // Asynchronous reset mid-dump at index 17; start pulsed while busy.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            start_a = (m_index_a == 5'd8);
            if (m_valid_a && (m_index_a == 5'd17)) found = 1'b1;
            else @(negedge clk);
        end
        start_a = 1'b0;
        if (!found) check_eq("rst_reach", 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_rdaddr", rd_addr_a, 32'd0);
        check_eq("arst_busy", busy_a, 32'd0);
        check_eq("arst_freeze", freeze_a, 32'd0);
        check_eq("arst_valid", m_valid_a, 32'd0);
        check_eq("arst_data", m_data_a, 32'd0);
        check_eq("arst_index", m_index_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("arst_stay_idle", busy_a, 32'd0);
        check_eq("arst_no_done", done_a, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
